// File: rtl/crypto_dec_engine.sv
// rtl/crypto_dec_engine.sv - iterative multi-round 16-bit decryption engine
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    ciphertext/key valid
//   in_ready    engine idle, can accept a block
//   ciphertext  block to decrypt
//   key         cipher key
//   flush       synchronous abort back to IDLE
//   out_valid   plaintext valid
//   out_ready   consumer accepts plaintext
//   plaintext   decrypted block (registered, changes only on entry to DONE)
//   busy        high while a block is in ROUND or DONE
module crypto_dec_engine #(
    parameter int NUM_ROUNDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ciphertext,
    input  logic [15:0] key,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] plaintext,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] st;
    logic [15:0] kr;
    logic [4:0]  cnt;

    logic [4:0]  ridx;
    logic [15:0] rk;
    logic [15:0] t;
    logic [15:0] m;
    logic [15:0] h;
    logic [15:0] r_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        case (x)
            8'h00: y = 8'h53;
            8'h01: y = 8'h6A;
            8'h02: y = 8'h87;
            8'h03: y = 8'hAC;
            8'h04: y = 8'hD1;
            8'h05: y = 8'hF6;
            8'h06: y = 8'h1B;
            8'h07: y = 8'h34;
            8'h08: y = 8'h49;
            8'h09: y = 8'h62;
            8'h0A: y = 8'h7D;
            8'h0B: y = 8'h96;
            8'h0C: y = 8'hBB;
            8'h0D: y = 8'hD8;
            8'h0E: y = 8'hF5;
            8'h0F: y = 8'h12;
            default: y = {x[3:0], x[7:4]};
        endcase
        return y;
    endfunction

    // Round keys are applied last-to-first; the index only matters in ROUND,
    // where cnt <= LAST so the subtraction never wraps.
    always_comb begin
        ridx  = LAST - cnt;
        // ridx = 0 makes the right shift 16, which yields zero: plain ROTL by 0.
        rk    = ((kr << ridx) | (kr >> (5'd16 - ridx))) ^ {11'h000, ridx};
        t     = st ^ rk;
        m     = t ^ {t[7:0], t[15:8]};
        h     = {m[7:0], m[15:8]};
        r_out = {sbox(h[15:8]), sbox(h[7:0])};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (in_valid) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == ROUND) || (state == DONE);
    end

    // Datapath: flush only clears the counter; plaintext keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= 16'h0000;
            kr        <= 16'h0000;
            cnt       <= 5'd0;
            plaintext <= 16'h0000;
        end else if (flush) begin
            cnt <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st  <= ciphertext;
                        kr  <= key;
                        cnt <= 5'd0;
                    end
                end
                ROUND: begin
                    st  <= r_out;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        plaintext <= r_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_dec_engine.sv
// tb/tb_crypto_dec_engine.sv - self-checking bench for crypto_dec_engine
module tb_crypto_dec_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // NUM_ROUNDS = 4 instance
    logic        iv, ir, fl, ov, ordy, bsy;
    logic [15:0] ct, ky, pt;
    // NUM_ROUNDS = 1 instance
    logic        iv1, ir1, fl1, ov1, ordy1, bsy1;
    logic [15:0] ct1, ky1, pt1;

    crypto_dec_engine #(.NUM_ROUNDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
        .ciphertext(ct), .key(ky), .flush(fl), .out_valid(ov),
        .out_ready(ordy), .plaintext(pt), .busy(bsy)
    );

    crypto_dec_engine #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .ciphertext(ct1), .key(ky1), .flush(fl1), .out_valid(ov1),
        .out_ready(ordy1), .plaintext(pt1), .busy(bsy1)
    );

    typedef struct {
        int          nr;
        logic [15:0] ct;
        logic [15:0] key;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    logic [15:0] q4[$];
    logic [15:0] q1[$];
    int          acc4 = 0, acc1 = 0;
    int          acc_cnt4 = 0, acc_cnt1 = 0;
    bit          seen4 = 1'b1, seen1 = 1'b1;
    bit          b2b4 = 1'b0, b2b1 = 1'b0;
    int          prev4 = -1, prev1 = -1;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [7:0] sb_ref(input logic [7:0] x);
        logic [127:0] tab;
        tab = 128'h536A87ACD1F61B3449627D96BBD8F512;
        if (x < 8'd16) return tab[127 - 8 * int'(x) -: 8];
        return {x[3:0], x[7:4]};
    endfunction

    function automatic logic [15:0] rotl_ref(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int j = 0; j < n; j++) r = {r[14:0], r[15]};
        return r;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] c, input logic [15:0] k, input int nr);
        logic [15:0] s, rk, t, m, h;
        s = c;
        for (int r = 0; r < nr; r++) begin
            rk = rotl_ref(k, nr - 1 - r) ^ {8'h00, 8'(nr - 1 - r)};
            t  = s ^ rk;
            m  = t ^ {t[7:0], t[15:8]};
            h  = {m[7:0], m[15:8]};
            s  = {sb_ref(h[15:8]), sb_ref(h[7:0])};
        end
        return s;
    endfunction

    // One clock: observe both DUTs at the falling edge (scoreboard push/pop,
    // latency and period checks), then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cycle++;
        if (!rst_n) begin
            q4.delete(); q1.delete();
            seen4 = 1'b1; seen1 = 1'b1;
        end else begin
            if (ov) begin
                chk1("ov4_expected", q4.size() != 0, 1'b1);
                if (!seen4) begin
                    seen4 = 1'b1;
                    chki("latency4", cycle - acc4, 5);
                end
            end
            if (fl) q4.delete();
            else begin
                if (ov && ordy && q4.size() != 0) chk16("sb_pt4", pt, q4.pop_front());
                if (iv && ir) begin
                    if (b2b4 && prev4 >= 0) chki("period4", cycle - prev4, 6);
                    prev4 = cycle; acc4 = cycle; seen4 = 1'b0; acc_cnt4++;
                    q4.push_back(model(ct, ky, 4));
                end
            end
            if (ov1) begin
                chk1("ov1_expected", q1.size() != 0, 1'b1);
                if (!seen1) begin
                    seen1 = 1'b1;
                    chki("latency1", cycle - acc1, 2);
                end
            end
            if (fl1) q1.delete();
            else begin
                if (ov1 && ordy1 && q1.size() != 0) chk16("sb_pt1", pt1, q1.pop_front());
                if (iv1 && ir1) begin
                    if (b2b1 && prev1 >= 0) chki("period1", cycle - prev1, 3);
                    prev1 = cycle; acc1 = cycle; seen1 = 1'b0; acc_cnt1++;
                    q1.push_back(model(ct1, ky1, 1));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_blk(input int nr, input logic [15:0] c, input logic [15:0] k,
                           output logic [15:0] got);
        int start;
        int n;
        if (nr == 1) begin
            ct1 = c; ky1 = k; iv1 = 1'b1; ordy1 = 1'b1; start = acc_cnt1;
        end else begin
            ct = c; ky = k; iv = 1'b1; ordy = 1'b1; start = acc_cnt4;
        end
        n = 0;
        while (((nr == 1) ? acc_cnt1 : acc_cnt4) == start && n < 20) begin
            tick(); n++;
        end
        iv = 1'b0; iv1 = 1'b0;
        chk1("accept_wait", ((nr == 1) ? acc_cnt1 : acc_cnt4) != start, 1'b1);
        n = 0;
        while (!((nr == 1) ? ov1 : ov) && n < 40) begin
            tick(); n++;
        end
        chk1("done_wait", (nr == 1) ? ov1 : ov, 1'b1);
        got = (nr == 1) ? pt1 : pt;
        tick();
    endtask

    initial begin
        logic [15:0] got;
        int n;
        int s4, s1;

        rst_n = 1'b0;
        iv = 1'b0; fl = 1'b0; ordy = 1'b1; ct = 16'h0; ky = 16'h0;
        iv1 = 1'b0; fl1 = 1'b0; ordy1 = 1'b1; ct1 = 16'h0; ky1 = 16'h0;
        tick(); tick();
        chk1("rst_in_ready", ir, 1'b1);
        chk1("rst_out_valid", ov, 1'b0);
        chk1("rst_busy", bsy, 1'b0);
        chk16("rst_plaintext", pt, 16'h0000);
        chk1("rst_in_ready1", ir1, 1'b1);
        rst_n = 1'b1;
        tick();

        // Zero block with round-by-round state visibility
        ct = 16'h0000; ky = 16'h0000; ordy = 1'b1; iv = 1'b1;
        tick();
        iv = 1'b0;
        chk1("round_busy", bsy, 1'b1);
        chk1("round_in_ready", ir, 1'b0);
        tick(); chk16("st_r1", dut.st, 16'hACAC);
        tick(); chk16("st_r2", dut.st, 16'h8787);
        tick(); chk16("st_r3", dut.st, 16'h6A6A);
        chk1("no_early_ov", ov, 1'b0);
        tick();
        chk1("done_ov", ov, 1'b1);
        chk16("done_pt", pt, 16'h5353);
        tick();
        chk1("idle_in_ready", ir, 1'b1);
        chk1("idle_ov", ov, 1'b0);

        // Table of vectors across both instances
        vecs[0] = '{4, 16'h0000, 16'h0000, 16'h5353};
        vecs[1] = '{1, 16'hAB00, 16'h0000, 16'hBABA};
        vecs[2] = '{1, 16'h1234, 16'h1234, 16'h5353};
        vecs[3] = '{4, 16'hFFFF, 16'h0000, 16'h0};
        vecs[4] = '{4, 16'h1234, 16'hABCD, 16'h0};
        vecs[5] = '{4, 16'h8001, 16'h7FFE, 16'h0};
        vecs[6] = '{1, 16'hC3A5, 16'h5A3C, 16'h0};
        vecs[7] = '{4, 16'h0F0F, 16'hF00F, 16'h0};
        for (int i = 3; i < 8; i++) vecs[i].exp = model(vecs[i].ct, vecs[i].key, vecs[i].nr);
        for (int i = 0; i < 8; i++) begin
            run_blk(vecs[i].nr, vecs[i].ct, vecs[i].key, got);
            chk16("vec_pt", got, vecs[i].exp);
        end

        // Backpressure: result must hold, no new block accepted
        ordy = 1'b0; ct = 16'h0000; ky = 16'h0000; iv = 1'b1;
        tick();
        iv = 1'b0;
        n = 0;
        while (!ov && n < 20) begin tick(); n++; end
        chk1("bp_reach_done", ov, 1'b1);
        iv = 1'b1; ct = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_ov_hold", ov, 1'b1);
            chk16("bp_pt_hold", pt, 16'h5353);
            chk1("bp_in_ready", ir, 1'b0);
        end
        iv = 1'b0; ordy = 1'b1;
        tick();
        chk1("bp_release_ov", ov, 1'b0);
        chk1("bp_release_ir", ir, 1'b1);

        // Reset in the middle of ROUND
        ct = 16'h1234; ky = 16'hABCD; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick(); tick();
        chki("mid_cnt", int'(dut.cnt), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("mid_rst_ir", ir, 1'b1);
        chk1("mid_rst_ov", ov, 1'b0);
        chk1("mid_rst_busy", bsy, 1'b0);
        chk16("mid_rst_pt", pt, 16'h0000);
        run_blk(4, 16'h0000, 16'h0000, got);
        chk16("post_rst_pt", got, 16'h5353);

        // Flush during ROUND
        ct = 16'h5555; ky = 16'h1111; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        fl = 1'b1;
        tick();
        fl = 1'b0;
        chk1("flush_ir", ir, 1'b1);
        chk1("flush_busy", bsy, 1'b0);
        chk1("flush_ov", ov, 1'b0);
        chk16("flush_pt_kept", pt, 16'h5353);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("flush_no_ov", ov, 1'b0);
        end

        // Flush together with in_valid in IDLE: nothing accepted
        fl = 1'b1; iv = 1'b1; ct = 16'h0001;
        tick();
        fl = 1'b0; iv = 1'b0;
        chk1("flush_iv_ir", ir, 1'b1);
        chk1("flush_iv_busy", bsy, 1'b0);
        tick();
        chk1("flush_iv_busy2", bsy, 1'b0);

        // Back-to-back blocks on both instances
        s4 = acc_cnt4; s1 = acc_cnt1;
        prev4 = -1; prev1 = -1; b2b4 = 1'b1; b2b1 = 1'b1;
        ordy = 1'b1; ordy1 = 1'b1; iv = 1'b1; iv1 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ct = 16'($urandom); ky = 16'($urandom);
            ct1 = 16'($urandom); ky1 = 16'($urandom);
            tick();
        end
        iv = 1'b0; iv1 = 1'b0; b2b4 = 1'b0; b2b1 = 1'b0;
        chk1("b2b_count4", (acc_cnt4 - s4) >= 9, 1'b1);
        chk1("b2b_count1", (acc_cnt1 - s1) >= 19, 1'b1);
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 30) begin tick(); n++; end
        chki("drain_empty", q4.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
